// File: rtl/decode_scoreboard.sv
// Registered destination decoder and busy scoreboard with RAW/WAW stall, occupancy count and clear-error pulse.
// Optional build macro ZERO_REG_EN makes index 0 a hardwired-zero entry that is never tracked.
module decode_scoreboard #(
  parameter  int SEL_W   = 3,
  localparam int ENTRIES = 2 ** SEL_W,
  localparam int CNT_W   = SEL_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [SEL_W-1:0]   set_sel,
  input  logic               clr_en,
  input  logic [SEL_W-1:0]   clr_sel,
  input  logic [SEL_W-1:0]   rd_sel_a,
  input  logic [SEL_W-1:0]   rd_sel_b,
  output logic [ENTRIES-1:0] wr_onehot,
  output logic [ENTRIES-1:0] busy,
  output logic               busy_a,
  output logic               busy_b,
  output logic               stall,
  output logic [CNT_W-1:0]   count,
  output logic               clr_err
);

`ifdef ZERO_REG_EN
  localparam logic [ENTRIES-1:0] LIVE_MASK = ~ENTRIES'(1);
`else
  localparam logic [ENTRIES-1:0] LIVE_MASK = '1;
`endif

  logic [ENTRIES-1:0] clr_dec;
  logic [ENTRIES-1:0] set_hit;
  logic [ENTRIES-1:0] busy_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               waw;
  logic               set_acc;
  logic               set_new;
  logic               clr_eff;
  logic               clr_err_nxt;

  // Unmasked clear decode drives the bypass; a hardwired-zero entry is never busy, so masking it is moot there.
  assign clr_dec   = clr_en ? (ENTRIES'(1) << clr_sel) : '0;
  assign wr_onehot = clr_dec & LIVE_MASK;

  assign busy_a  = busy[rd_sel_a] & ~clr_dec[rd_sel_a];
  assign busy_b  = busy[rd_sel_b] & ~clr_dec[rd_sel_b];
  assign waw     = set_en & busy[set_sel] & ~clr_dec[set_sel];
  assign stall   = busy_a | busy_b | waw;
  assign set_acc = set_en & ~stall;

  // Set wins over a same-entry clear, so that pair leaves the bit busy and the count unchanged.
  assign set_hit     = (set_acc ? (ENTRIES'(1) << set_sel) : '0) & LIVE_MASK;
  assign busy_nxt    = (busy & ~clr_dec) | set_hit;
  assign set_new     = |(set_hit & ~busy);
  assign clr_eff     = |(clr_dec & busy & ~set_hit);
  assign count_nxt   = count + CNT_W'(set_new) - CNT_W'(clr_eff);
  assign clr_err_nxt = clr_en & ~busy[clr_sel] & LIVE_MASK[clr_sel];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      count   <= '0;
      clr_err <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      count   <= count_nxt;
      clr_err <= clr_err_nxt;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed self-checking bench for decode_scoreboard (SEL_W=3); expectations adapt to ZERO_REG_EN.
module tb_decode_scoreboard;

  localparam int SEL_W   = 3;
  localparam int ENTRIES = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               set_en = 1'b0;
  logic [SEL_W-1:0]   set_sel = '0;
  logic               clr_en = 1'b0;
  logic [SEL_W-1:0]   clr_sel = '0;
  logic [SEL_W-1:0]   rd_sel_a = '0;
  logic [SEL_W-1:0]   rd_sel_b = '0;
  logic [ENTRIES-1:0] wr_onehot;
  logic [ENTRIES-1:0] busy;
  logic               busy_a;
  logic               busy_b;
  logic               stall;
  logic [SEL_W:0]     count;
  logic               clr_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  decode_scoreboard #(.SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_sel   (set_sel),
    .clr_en    (clr_en),
    .clr_sel   (clr_sel),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .wr_onehot (wr_onehot),
    .busy      (busy),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .stall     (stall),
    .count     (count),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_en = 1'b0;
    clr_en = 1'b0;
  endtask

  task automatic fill_all();
    rd_sel_a = 3'd7;
    rd_sel_b = 3'd7;
    for (int i = 0; i < ENTRIES; i++) begin
      set_en  = 1'b1;
      set_sel = SEL_W'(i);
      step();
    end
    idle();
  endtask

  initial begin
    // Reset state before any clock edge
    #1;
    check("rst_busy", 32'(busy), 32'h00);
    check("rst_count", 32'(count), 0);
    check("rst_clr_err", 32'(clr_err), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_wr_onehot", 32'(wr_onehot), 32'h00);
    #11 rst_n = 1'b1;
    step();

    // Issue and retire index 3
    set_en = 1'b1; set_sel = 3'd3; #1;
    check("issue3_stall", 32'(stall), 0);
    step(); idle();
    check("issue3_busy", 32'(busy), 32'h08);
    check("issue3_count", 32'(count), 1);
    step();
    clr_en = 1'b1; clr_sel = 3'd3; #1;
    check("retire3_onehot", 32'(wr_onehot), 32'h08);
    step(); idle(); #1;
    check("retire3_busy", 32'(busy), 32'h00);
    check("retire3_count", 32'(count), 0);
    check("retire3_clr_err", 32'(clr_err), 0);
    check("idle_onehot", 32'(wr_onehot), 32'h00);

    // RAW hazard on 5 and same-cycle writeback bypass
    set_en = 1'b1; set_sel = 3'd5;
    step(); idle();
    rd_sel_a = 3'd5; rd_sel_b = 3'd1; #1;
    check("raw5_busy_a", 32'(busy_a), 1);
    check("raw5_stall", 32'(stall), 1);
    check("raw5_busy_b", 32'(busy_b), 0);
    clr_en = 1'b1; clr_sel = 3'd5; #1;
    check("byp5_busy_a", 32'(busy_a), 0);
    check("byp5_stall", 32'(stall), 0);
    rd_sel_b = 3'd5; #1;
    check("byp5_busy_b", 32'(busy_b), 0);
    step(); idle(); rd_sel_a = 3'd1; rd_sel_b = 3'd1; #1;
    check("byp5_busy_after", 32'(busy), 32'h00);

    // Simultaneous set/clear of busy index 2
    set_en = 1'b1; set_sel = 3'd2;
    step();
    check("set2_busy", 32'(busy), 32'h04);
    clr_en = 1'b1; clr_sel = 3'd2; #1;
    check("setclr2_stall", 32'(stall), 0);
    step(); idle(); #1;
    check("setclr2_busy", 32'(busy), 32'h04);
    check("setclr2_count", 32'(count), 1);
    check("setclr2_clr_err", 32'(clr_err), 0);
    clr_en = 1'b1; clr_sel = 3'd2;
    step(); idle(); #1;
    check("drain2_count", 32'(count), 0);

    // Fill every entry, then a ninth set stalls
    fill_all(); #1;
    check("fill_busy", 32'(busy), ZR ? 32'hFE : 32'hFF);
    check("fill_count", 32'(count), ZR ? 7 : 8);
    rd_sel_a = 3'd4; rd_sel_b = 3'd4;
    set_en = 1'b1; set_sel = 3'd4; #1;
    check("full_set4_stall", 32'(stall), 1);
    step(); idle(); #1;
    check("full_set4_busy", 32'(busy), ZR ? 32'hFE : 32'hFF);
    check("full_set4_count", 32'(count), ZR ? 7 : 8);

    // Full: set and clear of the same index bypass through waw
    rd_sel_a = 3'd0; rd_sel_b = 3'd0;
    clr_en = 1'b1; clr_sel = 3'd6; set_en = 1'b1; set_sel = 3'd6; #1;
    check("full_setclr6_stall", 32'(stall), ZR ? 0 : 1);
    rd_sel_a = 3'd6; rd_sel_b = 3'd6; #1;
    check("full_setclr6_stall2", 32'(stall), 0);
    step(); idle(); #1;
    check("full_setclr6_count", 32'(count), ZR ? 7 : 8);

    // Drain everything; clearing index 0 never flags an error
    for (int i = 0; i < ENTRIES; i++) begin
      clr_en = 1'b1; clr_sel = SEL_W'(i);
      step();
      check($sformatf("drain%0d_clr_err", i), 32'(clr_err), 0);
    end
    idle(); #1;
    check("drained_busy", 32'(busy), 32'h00);
    check("drained_count", 32'(count), 0);

    // Clear of a non-busy entry pulses clr_err for exactly one cycle
    clr_en = 1'b1; clr_sel = 3'd6;
    step(); idle(); #1;
    check("clr_err_pulse", 32'(clr_err), 1);
    check("clr_err_busy", 32'(busy), 32'h00);
    step();
    check("clr_err_drop", 32'(clr_err), 0);

    // Index 0 behaviour
    rd_sel_a = 3'd1; rd_sel_b = 3'd1;
    set_en = 1'b1; set_sel = 3'd0;
    step(); idle();
    check("set0_busy", 32'(busy), ZR ? 32'h00 : 32'h01);
    check("set0_count", 32'(count), ZR ? 0 : 1);
    rd_sel_a = 3'd0; #1;
    check("rd0_busy_a", 32'(busy_a), ZR ? 0 : 1);
    clr_en = 1'b1; clr_sel = 3'd0; #1;
    check("clr0_onehot", 32'(wr_onehot), ZR ? 32'h00 : 32'h01);
    step(); idle(); rd_sel_a = 3'd1; #1;
    check("clr0_clr_err", 32'(clr_err), 0);

    // Asynchronous reset mid-operation
    fill_all();
    step();
    check("prerst_busy", 32'(busy), ZR ? 32'hFE : 32'hFF);
    set_en = 1'b1; set_sel = 3'd1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'h00);
    check("async_rst_count", 32'(count), 0);
    check("async_rst_clr_err", 32'(clr_err), 0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Parametrised, registered successor to the datapath's combinational select decoders. It decodes a destination-register index into a one-hot write-enable vector and tracks which register entries have an outstanding write in a busy scoreboard. It also produces a stall for two read indices and maintains an occupancy count. It sits between instruction decode and the register file, and gates issue of dependent instructions.

## Interface
- SEL_W, 3, select width; ENTRIES = 2**SEL_W one-hot lines / scoreboard bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- set_en  in  1  issue request: mark entry set_sel busy
- set_sel  in  SEL_W  destination index to issue
- clr_en  in  1  writeback: clear entry clr_sel
- clr_sel  in  SEL_W  index retiring
- rd_sel_a  in  SEL_W  source index A to check
- rd_sel_b  in  SEL_W  source index B to check
- wr_onehot  out  ENTRIES  combinational one-hot decode of clr_sel, all-zero when clr_en=0 (register-file write enables)
- busy  out  ENTRIES  registered scoreboard state
- busy_a, busy_b  out  1  source A/B hazard (with clear bypass)
- stall  out  1  issue blocked this cycle
- count  out  SEL_W+1  number of busy entries
- clr_err  out  1  registered pulse: previous cycle cleared a non-busy entry

## Operation
- Decode: wr_onehot[i] = clr_en & (clr_sel == i); exactly one bit or none.
- Hazard: busy_a = busy[rd_sel_a] & ~(clr_en & clr_sel == rd_sel_a); busy_b likewise (same-cycle writeback bypass).
- waw = set_en & busy[set_sel] & ~(clr_en & clr_sel == set_sel).
- stall = busy_a | busy_b | waw (combinational; stall may assert with set_en=0).
- Accept: set_acc = set_en & ~stall. A stalled set is dropped; the requester holds and retries.
- Next state per entry i: busy[i] <= (busy[i] & ~clr_hit[i]) | set_hit[i], where set_hit = set_acc & set_sel==i; set has priority when set and clear hit the same entry in one cycle.
- Clear of a non-busy entry: no state change; clr_err=1 the next cycle for one cycle.
- count <= count + set_acc_new − clr_eff, where set_acc_new = set_acc & ~busy[set_sel] and clr_eff = clr_en & busy[clr_sel] & ~(set_acc & set_sel == clr_sel). count always equals popcount(busy); range 0..ENTRIES, no wrap.
- Full (count == ENTRIES): any set stalls through waw unless a same-index clear is bypassed.

## Timing
- Reset (async assert, sync-free deassert): busy=0, count=0, clr_err=0. wr_onehot, busy_a, busy_b and stall follow the inputs combinationally and are therefore 0 from reset state.
- Issue latency: busy bit visible on the cycle after an accepted set.
- Clear: effective the same cycle via bypass on busy_a/busy_b/waw; busy bit drops on the next edge.
- Reset asserted mid-operation clears all state immediately, independent of clk; in-flight sets are lost.

## Configuration
- ZERO_REG_EN defined: index 0 is hardwired zero. busy[0] is never set, set_sel=0 is accepted without effect on busy or count, rd_sel=0 never hazards, wr_onehot[0]=0, and a clear of index 0 does not raise clr_err.
- ZERO_REG_EN undefined: all ENTRIES indices are treated uniformly.

## Test plan
- Reset: drive rst_n=0 mid-run with busy=8'hFF → busy=0, count=0, clr_err=0 without a clock edge.
- Issue/retire: set 3 at cycle 0 → busy=8'h08, count=1 at cycle 1; clr 3 at cycle 2 → wr_onehot=8'h08 that cycle, busy=0 at cycle 3.
- RAW + bypass: busy[5]=1, rd_sel_a=5 → stall=1; same cycle clr_sel=5 → busy_a=0, stall=0.
- Simultaneous set/clr on index 2 with busy[2]=1 → accepted; busy[2] stays 1, count unchanged, clr_err=0.
- Fill: 8 sets to indices 0..7 → count=8; a 9th set to 4 → stall=1, busy unchanged; clr to non-busy after draining → clr_err pulse one cycle.
- ZERO_REG_EN: set 0 → busy=0, count=0; rd_sel_a=0 → busy_a=0; with macro undefined → busy=8'h01.
